// File: rtl/prf_valid_list_mp_if.sv
// Signal bundle between the rename/dispatch logic and the multi-port PRF valid list.
// The master drives dispatch, writeback and recovery inputs; the slave is the valid list.
interface prf_valid_list_mp_if #(
    parameter int PRF_SIZE  = 64,
    parameter int PRF_WIDTH = $clog2(PRF_SIZE),
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int NUM_RD    = 4
);
    logic                            ROB_mispredict_in;
    logic [PRF_SIZE-1:0]             RRAT_PRF_FL_in;
    logic [NUM_ALLOC-1:0]            alloc_en_in;
    logic [NUM_ALLOC*PRF_WIDTH-1:0]  alloc_idx_in;
    logic [NUM_WR-1:0]               ex_wr_en_in;
    logic [NUM_WR*PRF_WIDTH-1:0]     ex_wr_idx_in;
    logic [NUM_RD*PRF_WIDTH-1:0]     RAT_rd_idx_in;
    logic [NUM_RD-1:0]               rd_valid_out;
    logic [PRF_WIDTH:0]              valid_count_out;

    modport master (
        output ROB_mispredict_in, RRAT_PRF_FL_in, alloc_en_in, alloc_idx_in,
               ex_wr_en_in, ex_wr_idx_in, RAT_rd_idx_in,
        input  rd_valid_out, valid_count_out
    );

    modport slave (
        input  ROB_mispredict_in, RRAT_PRF_FL_in, alloc_en_in, alloc_idx_in,
               ex_wr_en_in, ex_wr_idx_in, RAT_rd_idx_in,
        output rd_valid_out, valid_count_out
    );
endinterface

// File: rtl/prf_valid_list_mp.sv
// Multi-port physical register ready-bit list: alloc clears, writeback sets,
// one-cycle mispredict recovery from the RRAT free list, registered occupancy count.
module prf_valid_list_mp #(
    parameter int PRF_SIZE  = 64,
    parameter int PRF_WIDTH = $clog2(PRF_SIZE),
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int NUM_RD    = 4,
    parameter int ZERO_PRF  = PRF_SIZE - 1
) (
    input logic               clock,
    input logic               reset,
    prf_valid_list_mp_if.slave bus
);
    // Decode vectors span the full index space so out-of-range indices land in
    // padding bits that are never written back into the valid array.
    localparam int DEPTH = 1 << PRF_WIDTH;

    logic [PRF_SIZE-1:0] valid_q;
    logic [PRF_SIZE-1:0] valid_d;
    logic [PRF_WIDTH:0]  valid_count_q;
    logic [PRF_WIDTH:0]  count_d;
    logic [DEPTH-1:0]    set_pad;
    logic [DEPTH-1:0]    clr_pad;
    logic [DEPTH-1:0]    hit_pad;
    logic [NUM_RD-1:0]   rd_valid;

    always_comb begin
        set_pad = '0;
        clr_pad = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.ex_wr_en_in[w]) begin
                set_pad[bus.ex_wr_idx_in[w*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (bus.alloc_en_in[k]) begin
                clr_pad[bus.alloc_idx_in[k*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
            end
        end
    end

    // Alloc beats writeback on the same entry: the writeback hit a stale mapping.
    always_comb begin
        valid_d = valid_q;
        if (bus.ROB_mispredict_in) begin
            valid_d = ~bus.RRAT_PRF_FL_in;
        end else begin
            valid_d = (valid_q | set_pad[PRF_SIZE-1:0]) & ~clr_pad[PRF_SIZE-1:0];
        end
        valid_d[ZERO_PRF] = 1'b1;
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < PRF_SIZE; i++) begin
            count_d = count_d + {{PRF_WIDTH{1'b0}}, valid_d[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q       <= '1;
            valid_count_q <= (PRF_WIDTH+1)'(PRF_SIZE);
        end else begin
            valid_q       <= valid_d;
            valid_count_q <= count_d;
        end
    end

    // Reads see the stored bit plus same-cycle writeback; same-cycle alloc is ignored.
    always_comb begin
        hit_pad                 = '0;
        hit_pad[PRF_SIZE-1:0]   = valid_q | set_pad[PRF_SIZE-1:0];
        rd_valid                = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_valid[r] = hit_pad[bus.RAT_rd_idx_in[r*PRF_WIDTH +: PRF_WIDTH]];
        end
        if (bus.ROB_mispredict_in) begin
            rd_valid = '0;
        end
        if (!reset) begin
            rd_valid = '1;
        end
    end

    assign bus.rd_valid_out    = rd_valid;
    assign bus.valid_count_out = valid_count_q;

endmodule

// File: tb/tb_prf_valid_list_mp.sv
// Directed and randomized bench for prf_valid_list_mp against an array-based ready-bit model.
module tb_prf_valid_list_mp;
    localparam int PRF_SIZE  = 64;
    localparam int PW        = 6;
    localparam int NUM_WR    = 2;
    localparam int NUM_ALLOC = 2;
    localparam int NUM_RD    = 4;
    localparam int ZERO      = PRF_SIZE - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prf_valid_list_mp_if #(.PRF_SIZE(PRF_SIZE), .PRF_WIDTH(PW), .NUM_WR(NUM_WR),
                           .NUM_ALLOC(NUM_ALLOC), .NUM_RD(NUM_RD)) bus ();

    prf_valid_list_mp #(.PRF_SIZE(PRF_SIZE), .PRF_WIDTH(PW), .NUM_WR(NUM_WR),
                        .NUM_ALLOC(NUM_ALLOC), .NUM_RD(NUM_RD), .ZERO_PRF(ZERO)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    bit model [PRF_SIZE];

    logic                 s_rst;
    logic                 s_misp;
    logic [PRF_SIZE-1:0]  s_fl;
    logic [NUM_ALLOC-1:0] s_aen;
    int                   s_aidx [NUM_ALLOC];
    logic [NUM_WR-1:0]    s_wen;
    int                   s_widx [NUM_WR];
    int                   s_ridx [NUM_RD];
    logic [NUM_RD-1:0]    rd_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < PRF_SIZE; i++) n += model[i];
        return n;
    endfunction

    function automatic bit model_read(input int idx);
        if (!s_rst) return 1'b1;
        if (s_misp) return 1'b0;
        for (int w = 0; w < NUM_WR; w++)
            if (s_wen[w] && s_widx[w] == idx) return 1'b1;
        return model[idx];
    endfunction

    task automatic quiet();
        s_rst  = 1'b1;
        s_misp = 1'b0;
        s_fl   = '0;
        s_aen  = '0;
        s_wen  = '0;
        for (int k = 0; k < NUM_ALLOC; k++) s_aidx[k] = 0;
        for (int w = 0; w < NUM_WR; w++) s_widx[w] = 0;
        for (int r = 0; r < NUM_RD; r++) s_ridx[r] = r;
    endtask

    // One clock: drive, check reads before the edge, advance model, check count after.
    task automatic step(input string tag);
        logic [NUM_RD-1:0] exp_rd;
        @(negedge clk);
        rst_n                 = s_rst;
        bus.ROB_mispredict_in = s_misp;
        bus.RRAT_PRF_FL_in    = s_fl;
        bus.alloc_en_in       = s_aen;
        bus.ex_wr_en_in       = s_wen;
        for (int k = 0; k < NUM_ALLOC; k++) bus.alloc_idx_in[k*PW +: PW] = PW'(s_aidx[k]);
        for (int w = 0; w < NUM_WR; w++) bus.ex_wr_idx_in[w*PW +: PW] = PW'(s_widx[w]);
        for (int r = 0; r < NUM_RD; r++) bus.RAT_rd_idx_in[r*PW +: PW] = PW'(s_ridx[r]);
        #1;
        for (int r = 0; r < NUM_RD; r++) exp_rd[r] = model_read(s_ridx[r]);
        rd_seen = bus.rd_valid_out;
        chk({tag, "_rd"}, 64'(rd_seen), 64'(exp_rd));
        if (!s_rst) begin
            for (int i = 0; i < PRF_SIZE; i++) model[i] = 1'b1;
        end else if (s_misp) begin
            for (int i = 0; i < PRF_SIZE; i++) model[i] = !s_fl[i];
        end else begin
            for (int w = 0; w < NUM_WR; w++) if (s_wen[w]) model[s_widx[w]] = 1'b1;
            for (int k = 0; k < NUM_ALLOC; k++) if (s_aen[k]) model[s_aidx[k]] = 1'b0;
        end
        model[ZERO] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_cnt"}, 64'(bus.valid_count_out), 64'(model_count()));
    endtask

    function automatic int rnd_idx();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, PRF_SIZE - 1));
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n                 = 1'b0;
        bus.ROB_mispredict_in = 1'b0;
        bus.RRAT_PRF_FL_in    = '0;
        bus.alloc_en_in       = '0;
        bus.alloc_idx_in      = '0;
        bus.ex_wr_en_in       = '0;
        bus.ex_wr_idx_in      = '0;
        bus.RAT_rd_idx_in     = '0;
        for (int i = 0; i < PRF_SIZE; i++) model[i] = 1'b1;

        quiet();
        s_rst = 1'b0;
        s_ridx[0] = 3; s_ridx[1] = 40; s_ridx[2] = 17; s_ridx[3] = 63;
        step("rst0");
        step("rst1");
        chk("rst_rd_all", 64'(rd_seen), 64'hF);
        chk("rst_count", 64'(bus.valid_count_out), 64);

        quiet();
        s_aen = 2'b11; s_aidx[0] = 5; s_aidx[1] = 9;
        step("alloc59");
        chk("alloc59_count", 64'(bus.valid_count_out), 62);

        quiet();
        s_ridx[0] = 5; s_ridx[1] = 9; s_ridx[2] = 0; s_ridx[3] = 1;
        step("read59");
        chk("read59_rd", 64'(rd_seen), 64'b1100);

        quiet();
        s_wen = 2'b01; s_widx[0] = 5;
        s_ridx[0] = 5; s_ridx[1] = 9; s_ridx[2] = 5; s_ridx[3] = 9;
        step("wb5");
        chk("wb5_bypass", 64'(rd_seen), 64'b0101);
        chk("wb5_count", 64'(bus.valid_count_out), 63);

        quiet();
        s_aen = 2'b01; s_aidx[0] = 12; s_wen = 2'b10; s_widx[1] = 12;
        step("coll12");
        chk("coll12_count", 64'(bus.valid_count_out), 62);
        quiet();
        s_ridx[0] = 12;
        step("coll12_rd");
        chk("coll12_read", 64'(rd_seen[0]), 0);

        quiet();
        s_aen = 2'b10; s_aidx[1] = 20;
        step("alloc20");
        chk("alloc20_count", 64'(bus.valid_count_out), 61);
        quiet();
        s_wen = 2'b11; s_widx[0] = 20; s_widx[1] = 20;
        step("dualwb20");
        chk("dualwb20_count", 64'(bus.valid_count_out), 62);

        quiet();
        s_aen = 2'b11; s_aidx[0] = 1; s_aidx[1] = 2;
        step("alloc12");
        quiet();
        s_aen = 2'b01; s_aidx[0] = 3;
        step("alloc3");
        chk("alloc3_count", 64'(bus.valid_count_out), 59);
        quiet();
        s_misp = 1'b1; s_fl = 64'hFFFF_FFFF_FFFF_FFFD;
        s_aen = 2'b01; s_aidx[0] = 1; s_wen = 2'b01; s_widx[0] = 30;
        s_ridx[0] = 1; s_ridx[1] = 63; s_ridx[2] = 30; s_ridx[3] = 7;
        step("misp");
        chk("misp_rd_zero", 64'(rd_seen), 0);
        chk("misp_count", 64'(bus.valid_count_out), 2);
        quiet();
        s_ridx[0] = 1; s_ridx[1] = 63; s_ridx[2] = 0; s_ridx[3] = 2;
        step("postmisp");
        chk("postmisp_rd", 64'(rd_seen), 64'b0011);

        quiet();
        s_aen = 2'b01; s_aidx[0] = ZERO;
        step("zalloc");
        quiet();
        s_ridx[0] = ZERO;
        step("zread");
        chk("zero_after_alloc", 64'(rd_seen[0]), 1);
        quiet();
        s_misp = 1'b1; s_fl = '1;
        step("zmisp");
        chk("zmisp_count", 64'(bus.valid_count_out), 1);
        quiet();
        s_ridx[0] = ZERO; s_ridx[1] = 4;
        step("zmisp_rd");
        chk("zero_after_misp", 64'(rd_seen[1:0]), 64'b01);

        for (int c = 0; c < 3000; c++) begin
            s_rst  = ($urandom_range(0, 59) != 0);
            s_misp = ($urandom_range(0, 15) == 0);
            s_fl   = {$urandom, $urandom};
            s_aen  = NUM_ALLOC'($urandom);
            s_wen  = NUM_WR'($urandom);
            for (int k = 0; k < NUM_ALLOC; k++) s_aidx[k] = rnd_idx();
            for (int w = 0; w < NUM_WR; w++) s_widx[w] = rnd_idx();
            for (int r = 0; r < NUM_RD; r++) begin
                if ($urandom_range(0, 2) == 0) s_ridx[r] = s_widx[$urandom_range(0, NUM_WR - 1)];
                else s_ridx[r] = rnd_idx();
            end
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prf_valid_list_mp.md
Name: prf_valid_list_mp

Overview:
Parametrised multi-port successor to the physical register file valid list. It holds one ready bit per physical register. Allocation ports clear bits at dispatch. Writeback (CDB) ports set them. Read ports report operand readiness to the RS with same-cycle writeback bypass. On branch mispredict it recovers in one cycle from the RRAT free list. It also exports a registered count of valid registers for occupancy monitoring.

Parameters:
PRF_SIZE, 64, number of physical registers
PRF_WIDTH, $clog2(PRF_SIZE), physical index width
NUM_WR, 2, writeback (CDB) ports
NUM_ALLOC, 2, dispatch allocation ports
NUM_RD, 4, read ports (2 per dispatched instruction)
ZERO_PRF, PRF_SIZE-1, hardwired zero register index, always valid

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
ROB_mispredict_in  in  1  recover valid list this cycle
RRAT_PRF_FL_in  in  PRF_SIZE  RRAT free list, bit=1 means the register is free
alloc_en_in  in  NUM_ALLOC  per-port allocation strobe
alloc_idx_in  in  NUM_ALLOC*PRF_WIDTH  destination PRFs allocated at dispatch
ex_wr_en_in  in  NUM_WR  per-port writeback strobe
ex_wr_idx_in  in  NUM_WR*PRF_WIDTH  PRFs written back this cycle
RAT_rd_idx_in  in  NUM_RD*PRF_WIDTH  source PRFs queried
rd_valid_out  out  NUM_RD  per-port readiness
valid_count_out  out  PRF_WIDTH+1  registered count of set valid bits

Behaviour:
- State: valid_q[PRF_SIZE]. valid_count_q[PRF_WIDTH+1].
- reset low at a rising edge: valid_q is set all ones and valid_count_q = PRF_SIZE. This overrides every other input. Reset asserted mid-recovery or mid-writeback still produces all ones on the next cycle.
- Next-state priority per entry i, highest first: reset, mispredict, alloc clear, writeback set, hold.
- Mispredict: valid_d[i] = ~RRAT_PRF_FL_in[i]. Committed mappings are ready. Free entries read 0. Alloc and writeback inputs in the same cycle are ignored.
- Alloc: for each port k with alloc_en_in[k], valid_d[alloc_idx_k] = 0.
- Writeback: for each port w with ex_wr_en_in[w], valid_d[ex_wr_idx_w] = 1.
- Alloc and writeback hitting the same index in one cycle: alloc wins and the result is 0. The writeback targeted a stale mapping.
- Duplicate indices across alloc ports or across writeback ports are legal and idempotent.
- ZERO_PRF is always valid. Alloc and mispredict never clear it, whatever RRAT_PRF_FL_in[ZERO_PRF] holds.
- Read ports are combinational, zero latency:
  - rd_valid_out[r] = valid_q[idx_r] OR (any enabled ex_wr_idx_w == idx_r).
  - Same-cycle alloc does not affect reads. Intra-group dependence is handled by the RAT.
- While ROB_mispredict_in = 1, rd_valid_out is forced to 0 because dispatch is squashed.
- While reset is asserted (low), rd_valid_out is all ones, matching the reset state.
- valid_count_out = popcount(valid_q). It is registered, computed from valid_d, and updates in the same cycle as valid_q. The range 0..PRF_SIZE needs PRF_WIDTH+1 bits.
- Indices are assumed < PRF_SIZE. Out-of-range indices are ignored on writes and read as 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> valid_count_out=64 and all rd_valid_out=1 for any index.
- Alloc then writeback: alloc idx 5 and 9 at cycle 1 -> next cycle reading 5 and 9 gives 0 and count=62. Writeback idx 5 on port 0 at cycle 3 -> rd_valid_out for 5 is 1 in that same cycle (bypass), and 9 stays 0. Count becomes 63 the cycle after.
- Alloc/writeback collision: alloc 12 and writeback 12 in the same cycle -> next cycle reading 12 gives 0 and count drops by 1 (if 12 was valid).
- Dual writeback: 2 ports writing 20 and 20 in one cycle -> 20 becomes valid and count increments by exactly 1.
- Mispredict: after allocating 1,2,3, assert mispredict with RRAT_PRF_FL_in=64'hFFFF_FFFF_FFFF_FFFD -> same-cycle rd_valid_out all 0. Next cycle only PRF 1 and ZERO_PRF 63 are valid and count=2. A same-cycle alloc of 1 is ignored.
- Zero register: alloc 63 and a mispredict mask with bit 63 set -> 63 always reads 1.
